// File: rtl/mlp_r_sample_sequencer_if.sv
// Handshake bundle between sample source/sink and the MLP sample sequencer.
interface mlp_r_sample_sequencer_if #(
  parameter int WIDTH_A  = 4,
  parameter int NUM_A    = 11,
  parameter int OUTWIDTH = 20,
  parameter int LABEL_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_A*WIDTH_A-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [LABEL_W-1:0]       out_label;
  logic [OUTWIDTH-1:0]      out_raw;

  // Source/sink side: offers vectors, accepts labels.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_label, out_raw
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_label, out_raw
  );
endinterface

// File: rtl/mlp_r_sample_sequencer.sv
// Sample sequencer for the combinational MLP regressor: accepts a feature
// vector, holds it on the datapath for a settle time, then captures, rounds
// and clamps the prediction into a label offered on a valid/ready output.
module mlp_r_sample_sequencer #(
  parameter int WIDTH_A       = 4,
  parameter int NUM_A         = 11,
  parameter int OUTWIDTH      = 20,
  parameter int FRAC_BITS     = 12,
  parameter int LABEL_W       = 4,
  parameter int MAX_LABEL     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mlp_r_sample_sequencer_if.slave  bus,
  output logic [NUM_A*WIDTH_A-1:0] mlp_inp,
  input  logic [OUTWIDTH-1:0]      mlp_out,
  output logic [CNT_W-1:0]         sample_count
);

  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IPW = OUTWIDTH - FRAC_BITS;
  localparam logic [FRAC_BITS-1:0] HALF  = {1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic [IPW:0]         MAX_R = (IPW+1)'(MAX_LABEL);
  localparam logic [SW-1:0]        LOAD  = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SW-1:0]       cnt;
  logic                accept;
  logic                out_hs;
  logic                capture;
  logic [IPW-1:0]      ip;
  logic [FRAC_BITS-1:0] fr;
  logic [IPW:0]        r;
  logic [LABEL_W-1:0]  label_nxt;
  logic [LABEL_W-1:0]  label_q;
  logic [OUTWIDTH-1:0] raw_q;

  // Handshake qualifiers; in_ready depends only on state and out_ready.
  always_comb begin
    bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    bus.out_valid = (state == HOLD);
    accept        = bus.in_valid && bus.in_ready;
    out_hs        = (state == HOLD) && bus.out_ready;
    capture       = (state == SETTLE) && (cnt == '0);
  end

  // Round half-down on the fraction, computed one bit wider so an all-ones
  // integer part cannot wrap, then saturate to MAX_LABEL.
  always_comb begin
    ip = mlp_out[OUTWIDTH-1:FRAC_BITS];
    fr = mlp_out[FRAC_BITS-1:0];
    r  = {1'b0, ip} + (IPW+1)'(fr > HALF);
    if (r > MAX_R) label_nxt = LABEL_W'(MAX_LABEL);
    else           label_nxt = r[LABEL_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a HOLD handshake with a waiting vector skips IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (capture) state_nxt = HOLD;
      HOLD:    if (out_hs) state_nxt = bus.in_valid ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: input vector, settle counter, captured result, count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mlp_inp      <= '0;
      cnt          <= '0;
      label_q      <= '0;
      raw_q        <= '0;
      sample_count <= '0;
    end else begin
      if (accept) begin
        mlp_inp <= bus.in_data;
        cnt     <= LOAD;
      end else if ((state == SETTLE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        raw_q   <= mlp_out;
        label_q <= label_nxt;
      end
      if (out_hs) sample_count <= sample_count + 1'b1;
    end
  end

  assign bus.out_label = label_q;
  assign bus.out_raw   = raw_q;

endmodule
